// File: rtl/maxima_coord_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : maxima_coord_collector_if
// Description : Pixel-result input, FIFO drain handshake and per-frame status
//               bundle for the maxima coordinate collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface maxima_coord_collector_if #(
  parameter int LW = 4
);
  // Pixel result stream from the local-maxima stage
  logic          in_valid;
  logic          in_sof;
  logic          in_flag;
  logic [7:0]    in_pixel;

  // Coordinate FIFO head, drained by the host
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_row;
  logic [7:0]    out_col;
  logic [7:0]    out_pixel;

  // Frame status
  logic          frame_done;
  logic [7:0]    max_count;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  // Producer/host side: drives the pixel stream and the drain ready
  modport master (
    output in_valid, in_sof, in_flag, in_pixel, out_ready,
    input  out_valid, out_row, out_col, out_pixel,
    input  frame_done, max_count, overflow, fifo_level
  );

  // Collector side
  modport slave (
    input  in_valid, in_sof, in_flag, in_pixel, out_ready,
    output out_valid, out_row, out_col, out_pixel,
    output frame_done, max_count, overflow, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/maxima_coord_collector.sv
`default_nettype none
// ============================================================================
// Module      : maxima_coord_collector
// Description : Tracks raster position of a local-maximum flag stream, queues
//               (row, col, pixel) of every flagged pixel in a small FIFO for
//               the host, and reports per-frame count, frame-done pulse and a
//               sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module maxima_coord_collector #(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6,
  parameter int DEPTH  = 8,
  parameter int LW     = $clog2(DEPTH) + 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  maxima_coord_collector_if.slave bus
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [7:0]      c_W    = 8'(WIDTH);
  localparam logic [7:0]      c_H    = 8'(HEIGHT);
  localparam logic [LW-1:0]   c_FULL = LW'(DEPTH);
  localparam logic [7:0]      c_SAT  = 8'hFF;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [7:0]      r_row;
  logic [7:0]      r_col;
  logic [7:0]      r_run;
  logic [7:0]      r_max_count;
  logic            r_frame_done;
  logic            r_overflow;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [23:0]     r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]  w_cur_row;
  logic [7:0]  w_cur_col;
  logic        w_col_end;
  logic        w_last;
  logic [7:0]  w_nxt_row;
  logic [7:0]  w_nxt_col;
  logic [7:0]  w_run_base;
  logic [7:0]  w_run_inc;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_flagged;
  logic        w_push;
  logic        w_drop;
  logic [23:0] w_head;

  // A start-of-frame pixel is always (1,1), regardless of where we thought we were
  assign w_cur_row = bus.in_sof ? 8'd1 : r_row;
  assign w_cur_col = bus.in_sof ? 8'd1 : r_col;
  assign w_col_end = (w_cur_col == c_W);
  assign w_last    = w_col_end && (w_cur_row == c_H);

  // Raster advance from the current pixel, wrapping at row and frame end
  always_comb begin
    w_nxt_row = w_cur_row;
    w_nxt_col = w_cur_col + 8'd1;
    if (w_col_end) begin
      w_nxt_col = 8'd1;
      w_nxt_row = (w_cur_row == c_H) ? 8'd1 : (w_cur_row + 8'd1);
    end
  end

  // An SOF pixel restarts the count (abandons any partial frame); it still
  // counts itself if flagged
  assign w_run_base = bus.in_sof ? 8'd0 : r_run;
  assign w_run_inc  = (bus.in_flag && (w_run_base != c_SAT)) ?
                      (w_run_base + 8'd1) : w_run_base;

  // FIFO handshake; a pop on the same edge frees a slot for a push when full
  assign w_full    = (r_level == c_FULL);
  assign w_empty   = (r_level == '0);
  assign w_pop     = !w_empty && bus.out_ready;
  assign w_flagged = bus.in_valid && bus.in_flag;
  assign w_push    = w_flagged && (!w_full || w_pop);
  assign w_drop    = w_flagged && w_full && !w_pop;

  // Head entry is read straight from storage; zeroed while the FIFO is empty
  assign w_head        = r_mem[r_rd_ptr];
  assign bus.out_valid = !w_empty;
  assign bus.out_row   = w_empty ? 8'd0 : w_head[23:16];
  assign bus.out_col   = w_empty ? 8'd0 : w_head[15:8];
  assign bus.out_pixel = w_empty ? 8'd0 : w_head[7:0];

  assign bus.frame_done = r_frame_done;
  assign bus.max_count  = r_max_count;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_level = r_level;

  // Raster position counters, advancing only on accepted pixels
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row <= 8'd1;
      r_col <= 8'd1;
    end else if (bus.in_valid) begin
      r_row <= w_nxt_row;
      r_col <= w_nxt_col;
    end
  end

  // Running maxima count, end-of-frame capture and one-cycle done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run        <= 8'd0;
      r_max_count  <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.in_valid) begin
        if (w_last) begin
          r_max_count  <= w_run_inc;
          r_run        <= 8'd0;
          r_frame_done <= 1'b1;
        end else begin
          r_run <= w_run_inc;
        end
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_cur_row, w_cur_col, bus.in_pixel};
  end

endmodule
`default_nettype wire

// File: tb/tb_maxima_coord_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxima_coord_collector
// Description : Self-checking bench: directed vector table, hand-written
//               corner sequences and randomized traffic against a linear-index
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxima_coord_collector;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;

  typedef struct {
    int row;
    int col;
    int pix;
  } ent_t;

  typedef struct {
    bit         v;
    bit         s;
    bit         f;
    logic [7:0] p;
    bit         r;
    bit         ev;
    int         elvl;
    int         erow;
    int         ecol;
    int         epix;
  } vec_t;

  logic clk;
  logic rst;

  maxima_coord_collector_if #(.LW(LW)) bus ();

  maxima_coord_collector #(
    .WIDTH (W),
    .HEIGHT(H),
    .DEPTH (D),
    .LW    (LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   fd_cnt = 0;
  ent_t recv[$];

  // Reference model: frame position as a linear pixel index
  int   m_idx, m_run, m_maxc;
  bit   m_ovf, m_fd;
  ent_t mq[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input bit s, input bit f,
                            input int p, input bit r, input bit rs);
    int cur;
    bit fdn;
    if (!rs) begin
      mq.delete();
      m_idx = 0; m_run = 0; m_maxc = 0; m_ovf = 0; m_fd = 0;
    end else begin
      fdn = 0;
      if (mq.size() > 0 && r) mq.delete(0);
      if (v) begin
        cur = s ? 0 : m_idx;
        if (s) m_run = 0;
        if (f) begin
          if (m_run < 255) m_run++;
          if (mq.size() < D) mq.push_back('{cur / W + 1, cur % W + 1, p});
          else m_ovf = 1;
        end
        if (cur == W * H - 1) begin
          m_maxc = m_run;
          m_run  = 0;
          fdn    = 1;
        end
        m_idx = (cur + 1) % (W * H);
      end
      m_fd = fdn;
    end
  endtask

  // One clock: drive inputs, note any pop, clock, then check against the model
  task automatic cyc(input bit v, input bit s, input bit f, input logic [7:0] p,
                     input bit r, input bit rs);
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_flag   = f;
    bus.in_pixel  = p;
    bus.out_ready = r;
    rst           = rs;
    if (rs && bus.out_valid && r)
      recv.push_back('{int'(bus.out_row), int'(bus.out_col), int'(bus.out_pixel)});
    @(posedge clk);
    #1;
    model_step(v, s, f, int'(p), r, rs);
    if (bus.frame_done) fd_cnt++;
    chk("valid", int'(bus.out_valid), int'(mq.size() > 0));
    chk("level", int'(bus.fifo_level), mq.size());
    if (mq.size() > 0) begin
      chk("row", int'(bus.out_row), mq[0].row);
      chk("col", int'(bus.out_col), mq[0].col);
      chk("pix", int'(bus.out_pixel), mq[0].pix);
    end
    chk("frame_done", int'(bus.frame_done), int'(m_fd));
    chk("max_count", int'(bus.max_count), m_maxc);
    chk("overflow", int'(bus.overflow), int'(m_ovf));
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 8'd0, 0, 0);
    cyc(0, 0, 0, 8'd0, 0, 0);
    recv.delete();
    fd_cnt = 0;
  endtask

  vec_t tbl[7];

  initial begin
    rst = 1'b0;
    bus.in_valid = 0; bus.in_sof = 0; bus.in_flag = 0; bus.in_pixel = 0; bus.out_ready = 0;

    // Directed vectors from reset at (1,1)
    tbl[0] = '{1, 1, 1, 8'd10, 0, 1, 1, 1, 1, 10};
    tbl[1] = '{1, 0, 0, 8'd11, 0, 1, 1, 1, 1, 10};
    tbl[2] = '{0, 0, 1, 8'd99, 0, 1, 1, 1, 1, 10};
    tbl[3] = '{1, 0, 1, 8'd12, 0, 1, 2, 1, 1, 10};
    tbl[4] = '{1, 0, 0, 8'd13, 1, 1, 1, 1, 3, 12};
    tbl[5] = '{1, 0, 1, 8'd14, 1, 1, 1, 1, 5, 14};
    tbl[6] = '{0, 0, 0, 8'd0,  1, 0, 0, 0, 0, 0};

    // Reset state
    do_reset();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_level", int'(bus.fifo_level), 0);
    chk("rst_row", int'(bus.out_row), 0);
    chk("rst_col", int'(bus.out_col), 0);
    chk("rst_pix", int'(bus.out_pixel), 0);
    chk("rst_fd", int'(bus.frame_done), 0);
    chk("rst_maxc", int'(bus.max_count), 0);
    chk("rst_ovf", int'(bus.overflow), 0);

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].p, tbl[i].r, 1);
      chk("tbl_valid", int'(bus.out_valid), int'(tbl[i].ev));
      chk("tbl_level", int'(bus.fifo_level), tbl[i].elvl);
      if (tbl[i].ev) begin
        chk("tbl_row", int'(bus.out_row), tbl[i].erow);
        chk("tbl_col", int'(bus.out_col), tbl[i].ecol);
        chk("tbl_pix", int'(bus.out_pixel), tbl[i].epix);
      end
    end

    // Single frame, flags at (2,3)=200 and (5,6)=90
    do_reset();
    for (int k = 0; k < 36; k++) begin
      cyc(1, 0, (k == 8) || (k == 29), (k == 8) ? 8'd200 : ((k == 29) ? 8'd90 : 8'd7), 1, 1);
      if (k < 35) chk("f1_no_fd", int'(bus.frame_done), 0);
    end
    chk("f1_fd", int'(bus.frame_done), 1);
    chk("f1_maxc", int'(bus.max_count), 2);
    cyc(0, 0, 0, 8'd0, 1, 1);
    chk("f1_fd_low", int'(bus.frame_done), 0);
    cyc(0, 0, 0, 8'd0, 1, 1);
    chk("f1_nrecv", recv.size(), 2);
    if (recv.size() == 2) begin
      chk("f1_e0", recv[0].row * 65536 + recv[0].col * 256 + recv[0].pix, 2 * 65536 + 3 * 256 + 200);
      chk("f1_e1", recv[1].row * 65536 + recv[1].col * 256 + recv[1].pix, 5 * 65536 + 6 * 256 + 90);
    end
    chk("f1_ovf", int'(bus.overflow), 0);

    // Gapped input, flag on the last pixel only
    do_reset();
    for (int i = 0; i < 72; i++) begin
      cyc(i % 2 == 1, 0, (i % 2 == 1) && (i / 2 == 35), 8'd77, 1, 1);
      if (i < 71) chk("gap_no_fd", fd_cnt, 0);
    end
    chk("gap_fd", int'(bus.frame_done), 1);
    cyc(0, 0, 0, 8'd0, 1, 1);
    cyc(0, 0, 0, 8'd0, 1, 1);
    chk("gap_fd_cnt", fd_cnt, 1);
    chk("gap_nrecv", recv.size(), 1);
    if (recv.size() == 1)
      chk("gap_e0", recv[0].row * 65536 + recv[0].col * 256 + recv[0].pix, 6 * 65536 + 6 * 256 + 77);

    // Overflow: all 36 flagged, host stalled, then drain in order
    do_reset();
    for (int k = 0; k < 36; k++) cyc(1, 0, 1, 8'(k), 0, 1);
    chk("ovf_level", int'(bus.fifo_level), 8);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_maxc", int'(bus.max_count), 36);
    for (int j = 0; j < 8; j++) cyc(0, 0, 0, 8'd0, 1, 1);
    chk("ovf_nrecv", recv.size(), 8);
    for (int j = 0; j < 8 && j < recv.size(); j++)
      chk("ovf_order", recv[j].row * 65536 + recv[j].col * 256 + recv[j].pix,
          (j / 6 + 1) * 65536 + (j % 6 + 1) * 256 + j);

    // Reset mid-frame with 5 entries queued and overflow/max_count set
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 8'(50 + k), 0, 1);
    chk("mr_level_pre", int'(bus.fifo_level), 5);
    cyc(0, 0, 0, 8'd0, 0, 0);
    chk("mr_valid", int'(bus.out_valid), 0);
    chk("mr_level", int'(bus.fifo_level), 0);
    chk("mr_maxc", int'(bus.max_count), 0);
    chk("mr_ovf", int'(bus.overflow), 0);
    cyc(1, 0, 1, 8'd55, 0, 1);
    chk("mr_pos", int'(bus.out_row) * 256 + int'(bus.out_col), 257);

    // Full FIFO with a simultaneous pop and flagged push
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1, 0, 1, 8'(k), 0, 1);
    chk("fp_full", int'(bus.fifo_level), 8);
    cyc(1, 0, 1, 8'd123, 1, 1);
    chk("fp_level", int'(bus.fifo_level), 8);
    chk("fp_ovf", int'(bus.overflow), 0);
    for (int j = 0; j < 8; j++) cyc(0, 0, 0, 8'd0, 1, 1);
    chk("fp_nrecv", recv.size(), 9);
    if (recv.size() == 9)
      chk("fp_last", recv[8].row * 65536 + recv[8].col * 256 + recv[8].pix, 2 * 65536 + 3 * 256 + 123);

    // SOF at the 10th pixel abandons the partial frame
    do_reset();
    for (int k = 0; k < 9; k++) cyc(1, 0, (k == 2) || (k == 5), 8'(k), 1, 1);
    cyc(1, 1, 1, 8'd33, 1, 1);
    for (int k = 1; k < 36; k++) begin
      cyc(1, 0, (k == 10) || (k == 20) || (k == 35), 8'(k), 1, 1);
      if (k < 35) chk("sof_no_fd", fd_cnt, 0);
    end
    chk("sof_fd", int'(bus.frame_done), 1);
    chk("sof_maxc", int'(bus.max_count), 4);

    // Randomized traffic including occasional resync and reset
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, ($urandom % 64) == 0, ($urandom % 3) == 0,
          8'($urandom), ($urandom % 2) == 1, ($urandom % 400) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxima_coord_collector.md
Name: maxima_coord_collector

Overview:
- Downstream consumer of the local-maxima stage. Takes the raster-ordered 1-bit local-maximum flag stream and its 8-bit pixel values for a WIDTH x HEIGHT frame.
- Tracks the current row and column. Queues the (row, col, pixel) of every flagged pixel in a small FIFO, which the host drains over a valid/ready interface.
- Reports a per-frame maxima count, a frame-done pulse and a sticky overflow flag.

Parameters:
- WIDTH, 6, pixels per row (columns numbered 1..WIDTH)
- HEIGHT, 6, rows per frame (rows numbered 1..HEIGHT)
- DEPTH, 8, FIFO entries; must be a power of 2, >= 2
- LW, $clog2(DEPTH)+1, width of fifo_level

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  one pixel result presented this cycle
- in_sof  in  1  with in_valid: this pixel is row 1, col 1 (frame resync)
- in_flag  in  1  1 = pixel is a local maximum
- in_pixel  in  8  pixel value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head
- out_row  out  8  head row, 1-based
- out_col  out  8  head col, 1-based
- out_pixel  out  8  head pixel value
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- max_count  out  8  maxima in the last completed frame, saturating at 255
- overflow  out  1  sticky: a flagged pixel was dropped because the FIFO was full
- fifo_level  out  LW  current FIFO occupancy

Behaviour:
- Reset (rst=0 at posedge): row=1, col=1, FIFO empty (out_valid=0, fifo_level=0), out_row/out_col/out_pixel=0, frame_done=0, max_count=0, overflow=0, running count=0. Reset mid-operation discards all queued entries.
- Position counters advance only on an accept (in_valid=1):
  - in_sof=1 forces the current pixel to (1,1). Next position is (1,2), or (2,1) if WIDTH=1.
  - Otherwise the current pixel is the (row, col) registers. col increments; at col=WIDTH, col wraps to 1 and row increments; at (HEIGHT, WIDTH), both wrap to 1.
  - in_valid=0: counters, FIFO push and running count all hold.
- Running count increments (saturating at 255) on every accepted pixel with in_flag=1, whether or not the entry is pushed.
- Last pixel accepted at (HEIGHT, WIDTH), sof or not:
  - On that edge, max_count <= running count including this pixel; running count <= 0; frame_done is registered high.
  - frame_done is high for exactly the next cycle, then 0.
- in_sof=1 while not at (1,1): partial frame abandoned. The running count restarts (this pixel counts if flagged). No frame_done. FIFO contents are kept.
- Push condition: in_valid & in_flag & (!full | pop). The entry is {row, col, in_pixel} of the current pixel.
- Pop condition: out_valid & out_ready.
- Full with no pop: the entry is dropped and overflow <= 1. overflow stays 1 until reset.
- Push and pop on the same edge: both happen and fifo_level is unchanged, including when full.
- Pop when empty: not possible (out_valid=0), so out_ready is ignored.
- Latency: an entry pushed at edge N is visible with out_valid=1 from cycle N+1 (registered FIFO, no combinational in-to-out path). Entries leave in push order.
- out_row/out_col/out_pixel hold the head entry while out_valid=1. They are don't-care while out_valid=0.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- WIDTH and HEIGHT are each <= 255.

Test Plan:
- Reset, then one 6x6 frame with in_flag only at (2,3) pixel 200 and (5,6) pixel 90, out_ready=1 -> FIFO outputs (2,3,200) then (5,6,90). frame_done pulses one cycle after the 36th accept. max_count=2, overflow=0.
- Gapped input (in_valid toggles every other cycle), flag at (6,6) -> the entry is (6,6,x), and frame_done fires only after the 36th valid pixel.
- out_ready=0, all 36 pixels flagged with DEPTH=8 -> fifo_level saturates at 8 and overflow=1. Draining returns (1,1)..(2,2) in order. max_count=36.
- Full FIFO, flagged pixel arrives on the same edge that out_ready=1 pops -> entry accepted, fifo_level stays 8, overflow stays 0.
- in_sof asserted at the 10th pixel of a frame, then 36 clean pixels with 3 flags -> no frame_done for the aborted frame. Next frame_done has max_count=3, plus 1 if the sof pixel itself was flagged.
- rst=0 mid-frame with 5 entries queued -> next cycle out_valid=0, fifo_level=0, row=col=1, max_count=0, overflow=0.
